weights_replay_arbiter: RTL

//  Shares one synchronous-read weight memory (1-cycle read latency) between NUM_REQ replay clients.

---
 rtl/weights_replay_arbiter_if.sv | 42 ++++
 rtl/weights_replay_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/weights_replay_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : weights_replay_arbiter_if
// Purpose  : Request, memory-read and output-stream bundle for the
//            weights replay arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface weights_replay_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*LEN_W-1:0]  req_len;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      mem_rd_en;
  logic [ADDR_W-1:0]         mem_rd_addr;
  logic [DATA_W-1:0]         mem_rd_data;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic [IDX_W-1:0]          out_id;
  logic                      out_last;
  logic                      out_ready;
  logic                      busy;

  // The arbiter is the slave: it serves bursts to clients and the stream sink.
  modport slave (
    input  req_valid, req_addr, req_len, mem_rd_data, out_ready,
    output req_ready, mem_rd_en, mem_rd_addr, out_valid, out_data, out_id,
           out_last, busy
  );

  modport master (
    output req_valid, req_addr, req_len, mem_rd_data, out_ready,
    input  req_ready, mem_rd_en, mem_rd_addr, out_valid, out_data, out_id,
           out_last, busy
  );
endinterface
`default_nettype wire

// File: rtl/weights_replay_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : weights_replay_arbiter
// Purpose  : Round-robin burst arbiter sharing one 1-cycle-latency weight
//            memory between NUM_REQ replay clients; words stream out tagged
//            with the owner id. Define WEIGHTS_ARB_STATS_EN for per-client
//            16-bit saturating grant counters (grant_count).
// Revision : 1.0 - initial release
// ============================================================================
module weights_replay_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 4
) (
  input  wire                   clk,
  input  wire                   rst_n,
`ifdef WEIGHTS_ARB_STATS_EN
  output logic [NUM_REQ*16-1:0] grant_count,
`endif
  weights_replay_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] c_PTR_RESET = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_DATA = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_id;
  logic [ADDR_W-1:0]   r_cur_addr;
  logic [LEN_W-1:0]    r_remaining;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_last;
  logic                w_grant_any;
  logic [IDX_W-1:0]    w_grant_idx;
  logic [NUM_REQ-1:0]  w_req_ready;
  logic                w_mem_rd_en;

  // Walk from the largest offset down so the nearest client after r_ptr wins.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      if (bus.req_valid[(int'(r_ptr) + off) % NUM_REQ]) begin
        w_grant_any = 1'b1;
        w_grant_idx = IDX_W'((int'(r_ptr) + off) % NUM_REQ);
      end
    end
  end

  always_comb begin
    w_req_ready = '0;
    if (r_state == ST_IDLE && w_grant_any) begin
      w_req_ready[w_grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mem_rd_en = 1'b0;
    case (r_state)
      ST_IDLE: if (w_grant_any) w_state_nxt = ST_READ;
      ST_READ: begin
        w_mem_rd_en = 1'b1;
        w_state_nxt = ST_DATA;
      end
      ST_DATA: w_state_nxt = ST_OUT;
      ST_OUT: begin
        if (bus.out_ready) begin
          w_state_nxt = r_out_last ? ST_IDLE : ST_READ;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= c_PTR_RESET;
      r_id        <= '0;
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_any) begin
            r_ptr       <= w_grant_idx;
            r_id        <= w_grant_idx;
            r_cur_addr  <= bus.req_addr[int'(w_grant_idx)*ADDR_W +: ADDR_W];
            r_remaining <= bus.req_len[int'(w_grant_idx)*LEN_W +: LEN_W];
          end
        end
        ST_DATA: begin
          r_out_data  <= bus.mem_rd_data;
          r_out_valid <= 1'b1;
          r_out_last  <= (r_remaining == '0);
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            if (!r_out_last) begin
              r_cur_addr  <= r_cur_addr + ADDR_W'(1);
              r_remaining <= r_remaining - LEN_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready   = w_req_ready;
  assign bus.mem_rd_en   = w_mem_rd_en;
  assign bus.mem_rd_addr = w_mem_rd_en ? r_cur_addr : '0;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_data    = r_out_data;
  assign bus.out_id      = r_id;
  assign bus.out_last    = r_out_last;
  assign bus.busy        = (r_state != ST_IDLE);

`ifdef WEIGHTS_ARB_STATS_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
    logic [15:0] r_count;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_count <= '0;
      end else if (w_req_ready[gi] && r_count != 16'hFFFF) begin
        r_count <= r_count + 16'd1;
      end
    end
    assign grant_count[gi*16 +: 16] = r_count;
  end
`endif

endmodule
`default_nettype wire
